// File: rtl/dmem_stall_ctrl.sv
// Data-memory stall controller.
// Holds the pipeline while one MEM-stage load or store is carried out
// over a request/acknowledge memory port. A WAIT-cycle watchdog aborts
// accesses that never get acknowledged.
module dmem_stall_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15     // legal range 1..255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] addrM,
    input  logic [DATA_WIDTH-1:0] wdataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stop,
    output logic [DATA_WIDTH-1:0] rdataM,
    output logic                  err,
    output logic [15:0]           stall_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last WAIT count value before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       access;

    assign access = MemReadM | MemWriteM;

    // Freeze the pipeline from access detection until the access resolves;
    // DONE releases it for exactly one cycle so the access is not reissued.
    always_comb begin
        stop = 1'b0;
        if (!rst)
            stop = ((state == IDLE) && access) || (state == WAIT);
    end

    // Saturating count of cycles the pipeline was frozen.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (stop && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    // Access FSM: latch request in IDLE, wait for ack or timeout, one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdataM    <= '0;
            err       <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        // Write wins when both strobes are set.
                        mem_addr  <= addrM;
                        mem_wdata <= wdataM;
                        mem_we    <= MemWriteM;
                        mem_req   <= 1'b1;
                        wait_cnt  <= 8'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        // Ack takes precedence over a coincident timeout.
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (!mem_we)
                            rdataM <= mem_rdata;
                    end else if (wait_cnt == TO_LAST) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        err     <= 1'b1;
                        if (!mem_we)
                            rdataM <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
